// File: rtl/gf2m_163_reducer.sv
// gf2m_163_reducer
// Digit-serial modular reducer for GF(2^163), field polynomial
// f(x) = x^163 + x^7 + x^6 + x^3 + 1 (NIST B-163).
// Takes the 326-bit unreduced carry-less product from the multiplier and
// returns the canonical 163-bit field element. Each RUN cycle folds DIGIT
// high-order accumulator bits, working MSB-first.
//
// Parameters:
//   DIGIT      bits folded per cycle, legal range 1..32
//              (NCYC = ceil(163/DIGIT) fold cycles per operand)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_data is valid
//   in_ready   reducer can accept an operand (IDLE only, low during reset)
//   in_data    326-bit unreduced product, bit i = coefficient of x^i
//   out_valid  out_data holds a finished result (DONE)
//   out_ready  downstream accepts out_data
//   out_data   163-bit reduced result
//   out_zero   only with GF163_RED_ZERO_FLAG_EN defined: registered flag,
//              high iff out_data == 0, valid with out_valid
module gf2m_163_reducer #(
  parameter int unsigned DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [325:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef GF163_RED_ZERO_FLAG_EN
  output logic         out_zero,
`endif
  output logic [162:0] out_data
);

  localparam int unsigned M    = 163;
  localparam int unsigned W    = 2 * M;
  localparam int unsigned NCYC = (M + DIGIT - 1) / DIGIT;
  localparam int unsigned CW   = $clog2(NCYC + 1);
  // Low-order part of f(x): x^7 + x^6 + x^3 + 1
  localparam logic [7:0]  POLY_LOW = 8'hC9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_fold;
  logic [CW-1:0] cnt;
  logic          last_digit;

  assign last_digit = (cnt == CW'(NCYC - 1));

  // State register.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its sources, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only (plus rst gating in_ready), so
  // there is no in_valid->in_ready or out_ready->out_valid path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Fold the current digit [hi : hi-DIGIT+1], hi = 325 - cnt*DIGIT.
  // Every folded bit x^k (k >= 163) is replaced by POLY_LOW * x^(k-163).
  // Those contributions land at most at bit k-156, strictly below the digit
  // being folded (DIGIT <= 32), so all bits of one digit read the
  // unmodified accumulator and can fold in parallel. Positions below 163 in
  // the last digit are skipped.
  always_comb begin
    int         k;
    logic [8:0] bit_idx;
    acc_fold = acc;
    k        = 0;
    bit_idx  = '0;
    for (int j = 0; j < int'(DIGIT); j++) begin
      k = int'(W - 1) - int'(cnt) * int'(DIGIT) - j;
      if (k >= int'(M)) begin
        bit_idx = k[8:0];
        if (acc[bit_idx]) begin
          acc_fold[bit_idx]                   = 1'b0;
          acc_fold[bit_idx - 9'(M) +: 8]     ^= POLY_LOW;
        end
      end
    end
  end

  // Datapath: load on acceptance, fold while running, hold otherwise.
  // NOTE: the accumulator is reset on purpose; it drives out_data directly
  // and out_data must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= in_data;
          cnt <= '0;
        end
        RUN: begin
          acc <= acc_fold;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = acc[M-1:0];

`ifdef GF163_RED_ZERO_FLAG_EN
  // Captured on the last fold so it is valid in the same cycle as out_valid.
  always_ff @(posedge clk) begin
    if (rst)                            out_zero <= 1'b0;
    else if (state == RUN && last_digit) out_zero <= (acc_fold[M-1:0] == '0);
  end
`endif

endmodule

// File: tb/tb_gf2m_163_reducer.sv
// Testbench for gf2m_163_reducer. Three instances (DIGIT = 8, 1, 32) share
// clk/rst; the table vectors run on all three, the handshake corner cases and
// the random product stream run on the DIGIT=8 instance.
`timescale 1ns/1ps
module tb_gf2m_163_reducer;

  localparam int NDUT = 3;
  localparam int DIGS [NDUT] = '{8, 1, 32};
  localparam int NVEC = 8;
  localparam int NRAND = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [325:0] in_data   [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [162:0] out_data  [NDUT];
`ifdef GF163_RED_ZERO_FLAG_EN
  logic         out_zero  [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gf2m_163_reducer #(.DIGIT(DIGS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
`ifdef GF163_RED_ZERO_FLAG_EN
      .out_zero  (out_zero[g]),
`endif
      .out_data  (out_data[g])
    );
  end

  typedef struct {
    logic [325:0] din;
    logic [162:0] exp;
  } vec_t;

  vec_t         vecs [NVEC];
  logic [162:0] sb_q [$];
  int           checks   = 0;
  int           failures = 0;

  int           lat  [NDUT];
  logic         seen [NDUT];
  int           cyc;
  int           pulses;
  int           mon_got;
  int           mon_cyc;
  int           drv_guard;
  logic [325:0] op_a, op_b, rnd_p;

  task automatic check(input string name, input logic [162:0] act,
                       input logic [162:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ncyc(input int d);
    return (163 + d - 1) / d;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom();
    return t[162:0];
  endfunction

  // Software carry-less 163x163 multiply.
  function automatic logic [325:0] clmul(input logic [162:0] a,
                                         input logic [162:0] b);
    logic [325:0] p;
    p = '0;
    for (int i = 0; i < 163; i++)
      if (b[i]) p ^= {163'b0, a} << i;
    return p;
  endfunction

  // Bit-serial MSB-first long division by f(x).
  function automatic logic [162:0] ref_reduce(input logic [325:0] x);
    logic [325:0] r;
    logic [325:0] f;
    r = x;
    f = (326'b1 << 163) | 326'hC9;
    for (int k = 325; k >= 163; k--)
      if (r[k]) r ^= f << (k - 163);
    return r[162:0];
  endfunction

  // Wait (bounded) for out_valid on instance 0, counting edges.
  task automatic wait_valid0(input string name, input int exp_lat);
    cyc = 0;
    while (!out_valid[0] && cyc < 400) begin
      tick();
      cyc++;
    end
    check({name, "_latency"}, 163'(cyc), 163'(exp_lat));
  endtask

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      out_ready[g] = 1'b0;
    end

    // ---------------- reset ----------------
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready_low", 163'(in_ready[0]), 163'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 163'(in_ready[0]), 163'(1));
    check("post_rst_out_valid", 163'(out_valid[0]), 163'(0));
    check("post_rst_out_data", out_data[0], 163'h0);
`ifdef GF163_RED_ZERO_FLAG_EN
    check("post_rst_out_zero", 163'(out_zero[0]), 163'(0));
`endif

    // ---------------- table vectors on all three digit sizes ----------------
    vecs[0].din = 326'b1 << 163;                  vecs[0].exp = 163'hC9;
    vecs[1].din = 326'b1 << 324;                  vecs[1].exp = (163'b1 << 161) | 163'h1422;
    vecs[2].din = 326'h1234_5678;                 vecs[2].exp = 163'h1234_5678;
    vecs[3].din = '0;                             vecs[3].exp = '0;
    vecs[4].din = 326'b1 << 325;                  vecs[4].exp = (163'b1 << 162) | 163'h2844;
    vecs[5].din = {163'b0, {163{1'b1}}};          vecs[5].exp = {163{1'b1}};
    vecs[6].din = (326'b1 << 163) | (326'b1 << 162);
    vecs[6].exp = (163'b1 << 162) | 163'hC9;
    vecs[7].din = clmul(rand163(), rand163());
    vecs[7].exp = ref_reduce(vecs[7].din);

    for (int v = 0; v < NVEC; v++) begin
      for (int g = 0; g < NDUT; g++) begin
        in_valid[g] = 1'b1;
        in_data[g]  = vecs[v].din;
        lat[g]      = 9999;
        seen[g]     = 1'b0;
      end
      tick();  // acceptance edge
      for (int g = 0; g < NDUT; g++) in_valid[g] = 1'b0;
      cyc = 0;
      // out_ready stays low, so finished instances hold while slower ones run
      while (!(seen[0] && seen[1] && seen[2]) && cyc < 400) begin
        tick();
        cyc++;
        for (int g = 0; g < NDUT; g++)
          if (!seen[g] && out_valid[g]) begin
            seen[g] = 1'b1;
            lat[g]  = cyc;
          end
      end
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("vec%0d_d%0d_latency", v, DIGS[g]), 163'(lat[g]),
              163'(ncyc(DIGS[g])));
        check($sformatf("vec%0d_d%0d_data", v, DIGS[g]), out_data[g], vecs[v].exp);
`ifdef GF163_RED_ZERO_FLAG_EN
        check($sformatf("vec%0d_d%0d_zero", v, DIGS[g]), 163'(out_zero[g]),
              163'(vecs[v].exp == '0));
`endif
      end
      for (int g = 0; g < NDUT; g++) out_ready[g] = 1'b1;
      tick();  // transfer edge
      for (int g = 0; g < NDUT; g++) begin
        out_ready[g] = 1'b0;
        check($sformatf("vec%0d_d%0d_drop", v, DIGS[g]), 163'(out_valid[g]), 163'(0));
      end
    end

    // ---------------- backpressure with a second operand waiting ----------------
    op_a = clmul(rand163(), rand163());
    op_b = clmul(rand163(), rand163());
    in_valid[0] = 1'b1;
    in_data[0]  = op_a;
    tick();             // op_a accepted
    in_data[0]  = op_b; // op_b presented while busy, must be ignored
    wait_valid0("bp_a", ncyc(8));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d_valid", i), 163'(out_valid[0]), 163'(1));
      check($sformatf("bp_hold%0d_data", i), out_data[0], ref_reduce(op_a));
      check($sformatf("bp_hold%0d_in_ready", i), 163'(in_ready[0]), 163'(0));
      tick();
    end
    out_ready[0] = 1'b1;
    tick();             // op_a transferred
    out_ready[0] = 1'b0;
    check("bp_after_xfer_valid", 163'(out_valid[0]), 163'(0));
    check("bp_after_xfer_in_ready", 163'(in_ready[0]), 163'(1));
    tick();             // op_b accepted
    in_valid[0] = 1'b0;
    wait_valid0("bp_b", ncyc(8));
    check("bp_b_data", out_data[0], ref_reduce(op_b));
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // ---------------- reset in the middle of RUN ----------------
    op_a = clmul(rand163(), rand163());
    in_valid[0] = 1'b1;
    in_data[0]  = op_a;
    tick();             // accepted, counter = 0
    in_valid[0] = 1'b0;
    repeat (5) tick();  // counter = 5
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready_low", 163'(in_ready[0]), 163'(0));
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 163'(in_ready[0]), 163'(1));
    check("mid_rst_out_valid", 163'(out_valid[0]), 163'(0));
    check("mid_rst_out_data", out_data[0], 163'h0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid[0]) pulses++;
    end
    check("mid_rst_no_pulse", 163'(pulses), 163'(0));
    op_b = clmul(rand163(), rand163());
    in_valid[0] = 1'b1;
    in_data[0]  = op_b;
    tick();
    in_valid[0] = 1'b0;
    wait_valid0("mid_rst_fresh", ncyc(8));
    check("mid_rst_fresh_data", out_data[0], ref_reduce(op_b));
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // ---------------- random back-to-back products, scoreboard ----------------
    mon_got = 0;
    mon_cyc = 0;
    fork
      begin
        for (int n = 0; n < NRAND; n++) begin
          rnd_p = clmul(rand163(), rand163());
          in_valid[0] = 1'b1;
          in_data[0]  = rnd_p;
          drv_guard = 0;
          while (!in_ready[0] && drv_guard < 2000) begin
            tick();
            drv_guard++;
          end
          if (drv_guard >= 2000) begin
            check("rand_drv_timeout", 163'(drv_guard), 163'(0));
            break;
          end
          sb_q.push_back(ref_reduce(rnd_p));
          tick();  // acceptance edge
        end
        in_valid[0] = 1'b0;
      end
      begin
        while (mon_got < NRAND && mon_cyc < 60000) begin
          out_ready[0] = 1'($urandom_range(0, 1));
          if (out_valid[0] && out_ready[0]) begin
            if (sb_q.size() == 0)
              check("rand_unexpected_output", 163'(1), 163'(0));
            else
              check($sformatf("rand%0d", mon_got), out_data[0], sb_q.pop_front());
            mon_got++;
          end
          tick();
          mon_cyc++;
        end
        out_ready[0] = 1'b0;
      end
    join
    check("rand_count", 163'(mon_got), 163'(NRAND));
    check("rand_sb_empty", 163'(sb_q.size()), 163'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf2m_163_reducer.md
# gf2m_163_reducer

Digit-serial modular reducer for GF(2^163) using the NIST B-163 field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1. It accepts the unreduced 326-bit carry-less product from the 163x163 binary polynomial multiplier and returns the canonical 163-bit field element. It is the consumer end of the multiplier output path: multiplier → reducer → field-arithmetic datapath. A valid/ready handshake on both sides lets it absorb multiplier results and stall on downstream backpressure.

## Interface
Parameters:
- DIGIT, 8: high-order bits folded per cycle. Legal range 1..32.
- Derived: NCYC = ceil(163 / DIGIT), the fold cycles per operand (21 at the default).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  reducer can accept an operand.
- in_data  input  326  unreduced product; bit i is the coefficient of x^i.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  163  reduced result, degree ≤ 162.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, the next edge loads the 326-bit accumulator with in_data, clears the digit counter, and moves to RUN.
  - RUN: in_ready=0. Each cycle folds the DIGIT accumulator bits [hi : hi−DIGIT+1], where hi = 325 − counter·DIGIT. After NCYC cycles the FSM moves to DONE.
  - DONE: out_valid=1. When out_ready=1, the next edge moves back to IDLE.
- Fold rule:
  - Each accumulator bit k ≥ 163 that is set is cleared.
  - The constant 0xC9 (x^7+x^6+x^3+1) is XORed in at offset k−163.
  - All bits of one digit fold in the same cycle. DIGIT ≤ 32 < 156 guarantees no contribution lands inside the digit being folded, so the result equals MSB-first bit-serial reduction.
- In the final digit, positions below 163 are masked and never folded.
- out_data = accumulator[162:0]. It is held stable while out_valid=1 and not ready.
- in_data bit 325 is processed like any other bit. It never occurs from a 163x163 product but is still reduced correctly.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, out_data=0, accumulator=0, counter=0, state IDLE.
- rst asserted in any state aborts the operation on that edge. The in-flight operand is discarded and no out_valid pulse occurs.
- Latency:
  - The operand is accepted at edge t0.
  - out_valid rises after edge t0+NCYC (NCYC+1 edges in total).
  - It is first visible NCYC cycles after acceptance.
- Throughput: with out_ready tied high, one result every NCYC+2 cycles.
- in_valid arriving while in RUN or DONE is ignored. The source must hold it until in_ready.
- Output transfer and a new input acceptance never occur on the same edge. in_ready is low in DONE.
- out_valid stays high indefinitely under out_ready=0. No result is lost or overwritten.

## Configuration
- GF163_RED_ZERO_FLAG_EN:
  - Defined: adds output port out_zero (1 bit). It is registered and valid with out_valid, high iff out_data == 0. Its reset value is 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- in_data = 1<<163, DIGIT=8 → out_data = 0xC9; out_valid rises exactly 21 cycles after acceptance.
- in_data = 1<<324 → out_data = x^161 + x^12 + x^10 + x^5 + x (0x2 followed by 40 hex zeros, 0x1422 in the low bits). Repeat with DIGIT=1 and DIGIT=32; results must be identical.
- in_data = 0x1234_5678 (degree < 163) → out_data = 0x1234_5678. With GF163_RED_ZERO_FLAG_EN, in_data = 0 → out_data = 0 and out_zero = 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_data is stable and in_ready=0 throughout.
  - Present a second operand during the stall; it is accepted only after the first result transfers.
- Assert rst for one cycle mid-RUN (counter=5) → the next cycle shows in_ready=1 and out_valid=0. A fresh operand then reduces correctly.
- Random 1000 products of random 163-bit a×b (software carry-less multiply), fed back-to-back with random out_ready → every out_data matches the software reference modulo f(x).
